// File: rtl/aes_scan_ctrl.sv
// Scan-chain sequencer for an external AES engine: shifts {data,key,size,dec} in, waits for
// TRIG_COUNT synchronised triggers (or timeout), shifts the result out; done_o one cycle after FINISH.
module aes_scan_ctrl #(
    parameter int DATA_W      = 128,
    parameter int KEY_W       = 256,
    parameter int LANES       = 1,
    parameter int TRIG_COUNT  = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic              dec_i,
    output logic              scan_en_o,
    output logic [LANES-1:0]  scan_o,
    input  logic [LANES-1:0]  scan_i,
    output logic              engine_en_o,
    input  logic              trigger_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int VEC_L  = DATA_W + KEY_W + 3;
    localparam int N_IN   = (VEC_L + LANES - 1) / LANES;
    localparam int VEC_W  = N_IN * LANES;
    localparam int N_OUT  = (DATA_W + LANES - 1) / LANES;
    localparam int CAP_W  = N_OUT * LANES;
    localparam int SCNT_W = $clog2(N_IN + 1);
    localparam int TCNT_W = $clog2(TRIG_COUNT + 1);
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SCNT_W-1:0] IN_LAST  = SCNT_W'(N_IN - 1);
    localparam logic [SCNT_W-1:0] OUT_LAST = SCNT_W'(N_OUT - 1);
    localparam logic [TCNT_W-1:0] TRIG_LAST = TCNT_W'(TRIG_COUNT - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_RUN       = 3'd2,
        S_WAIT      = 3'd3,
        S_SHIFT_OUT = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    sreg_q, sreg_d;
    logic [CAP_W-1:0]    cap_q, cap_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [2:0]          sync_q;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [KEY_W-1:0]    key_mask;
    logic [VEC_W-1:0]    scan_vec;
    logic                trig_edge;
    int                  key_len;

    // Keys are left-aligned, so the unused low-order bits are the ones forced to zero.
    always_comb begin
        key_len = 256;
        case (size_i)
            2'b00:   key_len = 128;
            2'b01:   key_len = 192;
            default: key_len = 256;
        endcase
        key_mask = '1;
        for (int i = 0; i < KEY_W; i++) begin
            if (i < KEY_W - key_len) begin
                key_mask[i] = 1'b0;
            end
        end
        scan_vec = '0;
        scan_vec[VEC_W-1 -: VEC_L] = {data_i, key_i & key_mask, size_i, dec_i};
    end

    // sync_q[1] is the metastability-safe sample; sync_q[2] holds its previous value.
    assign trig_edge = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cap_d   = cap_q;
        scnt_d  = scnt_q;
        tcnt_d  = tcnt_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    if (size_i == 2'b11) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        sreg_d  = scan_vec;
                        scnt_d  = '0;
                        state_d = S_SHIFT_IN;
                    end
                end
            end
            S_SHIFT_IN: begin
                sreg_d = sreg_q << LANES;
                if (scnt_q == IN_LAST) begin
                    scnt_d  = '0;
                    state_d = S_RUN;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            S_RUN: begin
                wcnt_d  = '0;
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (trig_edge && (tcnt_q == TRIG_LAST)) begin
                    tcnt_d  = '0;
                    scnt_d  = '0;
                    state_d = S_SHIFT_OUT;
                end else if (wcnt_q == WAIT_LAST) begin
                    tcnt_d  = '0;
                    err_d   = 1'b1;
                    cap_d   = '0;
                    state_d = S_FINISH;
                end else if (trig_edge) begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_SHIFT_OUT: begin
                cap_d = (cap_q << LANES) | CAP_W'(scan_i);
                if (scnt_q == OUT_LAST) begin
                    scnt_d  = '0;
                    state_d = S_FINISH;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            S_FINISH: begin
                data_d  = cap_q[CAP_W-1 -: DATA_W];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cap_q   <= '0;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            wcnt_q  <= '0;
            sync_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cap_q   <= cap_d;
            scnt_q  <= scnt_d;
            tcnt_q  <= tcnt_d;
            wcnt_q  <= wcnt_d;
            sync_q  <= {sync_q[1:0], trigger_i};
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign scan_en_o   = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT);
    assign scan_o      = (state_q == S_SHIFT_IN) ? sreg_q[VEC_W-1 -: LANES] : '0;
    assign engine_en_o = (state_q == S_WAIT);
    assign data_o      = data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_aes_scan_ctrl.sv
// Bench for aes_scan_ctrl: a default instance (LANES=1) and a LANES=4 / TIMEOUT_CYC=100 instance,
// each driven by a bit-queue engine model that records the scan-in vector and returns a result.
`timescale 1ns/1ps
module tb_aes_scan_ctrl;
    localparam int DW = 128;
    localparam int KW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          load_a, load_b, trig_a, trig_b;
    logic [KW-1:0] key;
    logic [DW-1:0] data;
    logic [1:0]    size;
    logic          dec;
    logic [0:0]    scan_i_a, so_a;
    logic [3:0]    scan_i_b, so_b;
    logic          sen_a, en_a, busy_a, done_a, err_a;
    logic          sen_b, en_b, busy_b, done_b, err_b;
    logic [DW-1:0] dout_a, dout_b;

    aes_scan_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .load_i(load_a), .key_i(key), .data_i(data), .size_i(size),
        .dec_i(dec), .scan_en_o(sen_a), .scan_o(so_a), .scan_i(scan_i_a), .engine_en_o(en_a),
        .trigger_i(trig_a), .data_o(dout_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    aes_scan_ctrl #(.LANES(4), .TIMEOUT_CYC(100)) u_b (
        .clk(clk), .rst_n(rst_n), .load_i(load_b), .key_i(key), .data_i(data), .size_i(size),
        .dec_i(dec), .scan_en_o(sen_b), .scan_o(so_b), .scan_i(scan_i_b), .engine_en_o(en_b),
        .trigger_i(trig_b), .data_o(dout_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    int checks = 0;
    int errors = 0;

    logic          o_sen, o_en, o_busy, o_done, o_err;
    logic [3:0]    o_so;
    logic [DW-1:0] o_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int d);
        if (d == 0) begin
            o_sen = sen_a; o_so = {3'b000, so_a}; o_en = en_a; o_busy = busy_a;
            o_done = done_a; o_err = err_a; o_data = dout_a;
        end else begin
            o_sen = sen_b; o_so = so_b; o_en = en_b; o_busy = busy_b;
            o_done = done_b; o_err = err_b; o_data = dout_b;
        end
    endtask

    task automatic set_load(input int d, input logic v);
        if (d == 0) load_a = v; else load_b = v;
    endtask

    task automatic set_trig(input int d, input logic v);
        if (d == 0) trig_a = v; else trig_b = v;
    endtask

    task automatic set_scan(input int d, input logic [3:0] v);
        if (d == 0) scan_i_a = v[0:0]; else scan_i_b = v;
    endtask

    function automatic logic [DW-1:0] rnd_dw();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [KW-1:0] rnd_kw();
        logic [KW-1:0] v;
        for (int i = 0; i < KW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One complete operation. w1/w2 are WAIT-cycle indices of the two trigger pulses (<0: none);
    // rst_at > 0 asserts reset at that SHIFT_OUT beat instead of letting the operation finish.
    task automatic do_op(input int d, input logic [DW-1:0] din, input logic [KW-1:0] kin,
                         input logic [1:0] sz, input logic dc, input logic [DW-1:0] res,
                         input int w1, input int w2, input bit shift_trig, input bit hold_load,
                         input bit expect_to, input int rst_at, input string tag);
        int ln, klen, nin, nout, nwait, gap, wait_start, done_cyc, mism;
        bit ph, done_seen, busy_bad, aborted, done_any;
        bit expq[$];
        bit rxq[$];
        logic [3:0] v;
        ln = (d == 0) ? 1 : 4;
        klen = (sz == 2'b00) ? 128 : (sz == 2'b01) ? 192 : 256;
        for (int i = DW - 1; i >= 0; i--) expq.push_back(din[i]);
        for (int i = KW - 1; i >= 0; i--) expq.push_back((i >= KW - klen) ? kin[i] : 1'b0);
        expq.push_back(sz[1]);
        expq.push_back(sz[0]);
        expq.push_back(dc);
        while (expq.size() % ln != 0) expq.push_back(1'b0);
        nin = 0; nout = 0; nwait = 0; gap = 0; wait_start = 0; done_cyc = 0;
        ph = 0; done_seen = 0; busy_bad = 0; aborted = 0;
        data = din; key = kin; size = sz; dec = dc;
        set_load(d, 1'b1);
        for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
            step();
            sample(d);
            if (!hold_load || ph) set_load(d, 1'b0);
            set_trig(d, 1'b0);
            set_scan(d, 4'h0);
            if (rst_at > 0 && ph && o_sen && nout == rst_at) begin
                rst_n = 1'b0;
                #1;
                sample(d);
                chk({tag, "_rst_data"}, o_data, '0);
                chk({tag, "_rst_ctl"}, {o_busy, o_done, o_err, o_sen, o_en, o_so}, '0);
                done_any = 0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    sample(d);
                    done_any |= o_done;
                end
                chk({tag, "_rst_nodone"}, done_any, 0);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            if (o_done) begin
                done_seen = 1;
                done_cyc = cyc;
            end else begin
                if (!o_busy) busy_bad = 1;
                if (o_sen && !ph) begin
                    for (int l = ln - 1; l >= 0; l--) rxq.push_back(o_so[l]);
                    nin++;
                    if (shift_trig && (nin == 10 || nin == 11 || nin == 40 || nin == 41 ||
                                       nin == 80 || nin == 81)) set_trig(d, 1'b1);
                end else if (o_en) begin
                    if (!ph) wait_start = cyc;
                    ph = 1;
                    if ((w1 >= 0 && (nwait == w1 || nwait == w1 + 1)) ||
                        (w2 >= 0 && (nwait == w2 || nwait == w2 + 1))) set_trig(d, 1'b1);
                    nwait++;
                end else if (o_sen && ph) begin
                    v = '0;
                    for (int l = 0; l < ln; l++) v[ln-1-l] = res[DW-1-(nout*ln+l)];
                    set_scan(d, v);
                    nout++;
                end else if (!ph && nin > 0) begin
                    gap++;
                end
            end
        end
        if (!aborted) begin
            chk({tag, "_done_seen"}, done_seen, 1);
            chk({tag, "_nin"}, nin, ((DW + KW + 3) + ln - 1) / ln);
            mism = 0;
            if (rxq.size() != expq.size()) mism = 9999;
            else foreach (expq[i]) if (rxq[i] !== expq[i]) mism++;
            chk({tag, "_scanvec_mism"}, mism, 0);
            chk({tag, "_run_gap"}, gap, 1);
            chk({tag, "_busy_hole"}, busy_bad, 0);
            if (expect_to) begin
                chk({tag, "_to_latency"}, done_cyc - wait_start, 101);
                chk({tag, "_to_err"}, o_err, 1);
                chk({tag, "_to_data"}, o_data, '0);
                chk({tag, "_to_nout"}, nout, 0);
            end else begin
                chk({tag, "_nout"}, nout, DW / ln);
                chk({tag, "_data"}, o_data, res);
                chk({tag, "_err"}, o_err, 0);
                if (w2 >= 0) chk({tag, "_late_done"}, nwait > w2 + 1, 1);
            end
            step();
            sample(d);
            chk({tag, "_done_pulse"}, o_done, 0);
            chk({tag, "_idle"}, o_busy, 0);
        end
    endtask

    logic [DW-1:0] prev;
    int            w1;

    initial begin
        rst_n = 1'b0;
        load_a = 1'b0; load_b = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
        scan_i_a = '0; scan_i_b = '0;
        key = '0; data = '0; size = 2'b00; dec = 1'b0;
        repeat (3) step();
        sample(0);
        chk("reset_a", {o_data, o_busy, o_done, o_err, o_sen, o_en, o_so}, '0);
        sample(1);
        chk("reset_b", {o_data, o_busy, o_done, o_err, o_sen, o_en, o_so}, '0);
        rst_n = 1'b1;
        step();

        do_op(0, 128'h00112233445566778899aabbccddeeff, '0, 2'b10, 1'b0,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 15, 0, 0, 0, 0, "fips");

        prev = dout_a;
        data = rnd_dw(); key = rnd_kw(); size = 2'b11; dec = 1'b0;
        load_a = 1'b1;
        step();
        sample(0);
        load_a = 1'b0;
        chk("sz11_done", o_done, 1);
        chk("sz11_err", o_err, 1);
        chk("sz11_busy", o_busy, 0);
        chk("sz11_data", o_data, prev);
        step();
        sample(0);
        chk("sz11_pulse", o_done, 0);
        chk("sz11_sticky", {o_err, o_busy}, 2'b10);
        chk("sz11_data2", o_data, prev);

        do_op(0, rnd_dw(), rnd_kw(), 2'b10, 1'b1, rnd_dw(), 3, 30, 1, 1, 0, 0, "noisy");

        for (int n = 0; n < 4; n++) begin
            w1 = $urandom_range(0, 20);
            do_op(1, rnd_dw(), rnd_kw(), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  rnd_dw(), w1, w1 + 4 + $urandom_range(0, 25), 0, 0, 0, 0, "rnd_b");
        end

        do_op(1, rnd_dw(), '1, 2'b00, 1'b0, rnd_dw(), 2, 9, 1, 0, 0, 0, "l4_k128");
        do_op(1, rnd_dw(), rnd_kw(), 2'b01, 1'b1, rnd_dw(), -1, -1, 0, 0, 1, 0, "timeout");
        do_op(1, rnd_dw(), rnd_kw(), 2'b10, 1'b0, rnd_dw(), 1, 6, 0, 0, 0, 0, "after_to");

        do_op(0, rnd_dw(), rnd_kw(), 2'b01, 1'b0, rnd_dw(), 4, 12, 0, 0, 0, 50, "rst_mid");
        do_op(0, rnd_dw(), rnd_kw(), 2'b00, 1'b1, rnd_dw(), 2, 8, 0, 0, 0, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_scan_ctrl.md
AES_SCAN_CTRL -- requirements
Module: aes_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 128, text block width in bits.
REQ-002 SHALL have parameter KEY_W, default 256, maximum key width in bits.
REQ-003 SHALL have parameter LANES, default 1, scan lanes shifted per clock; legal values 1, 2, 4, 8.
REQ-004 SHALL have parameter TRIG_COUNT, default 2, engine trigger pulses that mark completion.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535, maximum WAIT cycles before abort.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port load_i, input, 1, start request; sampled only in IDLE.
REQ-009 SHALL have port key_i, input, KEY_W, key, left-aligned for short keys.
REQ-010 SHALL have port data_i, input, DATA_W, plaintext or ciphertext.
REQ-011 SHALL have port size_i, input, 2, key size select: 00=128, 01=192, 10=256, 11=reserved.
REQ-012 SHALL have port dec_i, input, 1, 1=decrypt, 0=encrypt.
REQ-013 SHALL have port scan_en_o, output, 1, scan shift enable to the engine.
REQ-014 SHALL have port scan_o, output, LANES, scan data to the engine.
REQ-015 SHALL have port scan_i, input, LANES, scan data from the engine.
REQ-016 SHALL have port engine_en_o, output, 1, engine run enable.
REQ-017 SHALL have port trigger_i, input, 1, engine trigger; asynchronous to clk.
REQ-018 SHALL have port data_o, output, DATA_W, result block.
REQ-019 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-020 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-021 SHALL have port err_o, output, 1, sticky error; cleared on the next accepted load.

Function
REQ-022 SHALL implement states IDLE, SHIFT_IN, RUN, WAIT, SHIFT_OUT, FINISH; any illegal encoding SHALL go to IDLE.
REQ-023 SHALL, in IDLE with load_i=1 and size_i!=11, capture all inputs and enter SHIFT_IN on the next edge.
REQ-024 SHALL, in IDLE with load_i=1 and size_i=11, set err_o, pulse done_o for one cycle, leave data_o unchanged and remain in IDLE.
REQ-025 SHALL build scan vector {data, key, size[1:0], dec}: length L=DATA_W+KEY_W+3, zero-padded at LSB to a multiple of LANES.
REQ-026 SHALL zero the key bits beyond the selected key size before shifting.
REQ-027 SHALL, in SHIFT_IN, assert scan_en_o and drive scan_o MSB-first, LANES bits per cycle, for exactly ceil(L/LANES) cycles (387 at defaults).
REQ-028 SHALL spend one cycle in RUN with scan_en_o=0, then assert engine_en_o from WAIT entry until SHIFT_OUT entry.
REQ-029 SHALL pass trigger_i through a 2-flop synchroniser and count synchronised rising edges during WAIT only.
REQ-030 SHALL leave WAIT for SHIFT_OUT on the cycle the count reaches TRIG_COUNT; the counter SHALL clear on SHIFT_OUT entry.
REQ-031 SHALL count WAIT cycles; on reaching TIMEOUT_CYC it SHALL set err_o, zero data_o, skip SHIFT_OUT and enter FINISH.
REQ-032 SHALL, in SHIFT_OUT, assert scan_en_o, drive scan_o=0 and capture scan_i MSB-first for ceil(DATA_W/LANES) cycles.
REQ-033 SHALL, in FINISH, update data_o, pulse done_o for one cycle and return to IDLE; back-to-back loads are accepted from the following cycle.
REQ-034 SHALL ignore load_i whenever busy_o=1; in-flight operations are never restarted.
REQ-035 SHALL NOT count trigger edges arriving outside WAIT.

Reset
REQ-036 SHALL, while rst_n=0, enter IDLE with data_o=0, busy_o=0, done_o=0, err_o=0, scan_en_o=0, scan_o=0, engine_en_o=0 and all counters and synchroniser flops cleared.
REQ-037 SHALL, on reset asserted mid-operation, abort immediately with no done_o pulse; a new load is accepted on the first edge after release.

Verification
REQ-038 SHALL cover: defaults, data=00112233445566778899aabbccddeeff, key=0, size=10, dec=0, engine model returning 69c4e0d86a7b0430d8cdb78070b4c55a -> 387 scan_in cycles, then data_o equals that value with a done_o pulse.
REQ-039 SHALL cover: LANES=4, size=00 -> 97 shift-in cycles, key bits [127:0] shifted as zero, 32 shift-out cycles.
REQ-040 SHALL cover: size=11 load -> err_o=1, one done_o pulse, busy_o stays 0, data_o unchanged.
REQ-041 SHALL cover: TIMEOUT_CYC=100 with no trigger -> done_o 101 cycles after WAIT entry, err_o=1, data_o=0.
REQ-042 SHALL cover: trigger pulses during SHIFT_IN plus load_i held high while busy -> neither counted nor restarted; completion only after 2 WAIT-phase pulses.
REQ-043 SHALL cover: rst_n low during SHIFT_OUT -> all outputs return to reset values, no done_o; the next load completes normally.
